// File: rtl/mic_pkt_sched.sv
`default_nettype none
// ============================================================================
// Module   : mic_pkt_sched
// Purpose  : Mic FIFO read-side packetiser. Sends a 32-bit sequence number,
//            then SAMPLES_PER_PKT 16-bit samples MSB first, to the UDP TX mux.
//            Optional partial-packet timeout: define MIC_PKT_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module mic_pkt_sched #(
    parameter int SAMPLES_PER_PKT = 64,
    parameter int USEDW_W         = 11,
    parameter int TIMEOUT_CYCLES  = 2500000
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               run,
    input  logic [USEDW_W-1:0] fifo_rdusedw,
    input  logic               fifo_empty,
    input  logic [15:0]        fifo_rdata,
    output logic               fifo_rdreq,
    output logic               tx_req,
    input  logic               tx_grant,
    output logic [7:0]         tx_data,
    output logic               tx_valid,
    output logic               tx_last,
    output logic               underflow
);
    localparam int                 c_smp_w     = $clog2(SAMPLES_PER_PKT + 1);
    localparam logic [c_smp_w-1:0] c_last_smp  = c_smp_w'(SAMPLES_PER_PKT - 1);
    localparam logic [USEDW_W-1:0] c_full_used = USEDW_W'(SAMPLES_PER_PKT);

    if (SAMPLES_PER_PKT < 2 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("mic_pkt_sched: need SAMPLES_PER_PKT >= 2 and TIMEOUT_CYCLES >= 1");
    end

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_SEQ  = 3'd2,
        ST_RD   = 3'd3,
        ST_MSB  = 3'd4,
        ST_LSB  = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic [31:0]        seq_q, seq_d;
    logic [1:0]         byte_q, byte_d;
    logic [c_smp_w-1:0] smp_q, smp_d;
    logic [7:0]         lsb_q, lsb_d;
    logic               got_q, got_d;
    logic               fifo_rdreq_q, fifo_rdreq_d;
    logic               tx_req_q, tx_req_d;
    logic [7:0]         tx_data_q, tx_data_d;
    logic               tx_valid_q, tx_valid_d;
    logic               tx_last_q, tx_last_d;
    logic               underflow_q, underflow_d;
    logic               w_live;
    logic [31:0]        w_hdr;

`ifdef MIC_PKT_TIMEOUT_EN
    localparam int                 c_tmr_w    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_tmr_w-1:0] c_tmr_last = c_tmr_w'(TIMEOUT_CYCLES - 1);
    localparam logic [c_smp_w-1:0] c_full_pkt = c_smp_w'(SAMPLES_PER_PKT);
    logic [c_tmr_w-1:0] tmr_q, tmr_d;
    logic [c_smp_w-1:0] k_q, k_d;
`endif

    assign w_hdr = seq_q << {byte_q, 3'b000};

    // Outputs are registered, so bytes trail the state by one cycle; the
    // read strobe is issued on entry to RD so fifo_rdata lands during MSB.
    always_comb begin
        state_d      = state_q;
        seq_d        = seq_q;
        byte_d       = byte_q;
        smp_d        = smp_q;
        lsb_d        = lsb_q;
        got_d        = fifo_rdreq_q;
        tx_data_d    = 8'h00;
        tx_valid_d   = 1'b0;
        tx_last_d    = 1'b0;
        fifo_rdreq_d = 1'b0;
        underflow_d  = 1'b0;
        w_live       = 1'b1;
`ifdef MIC_PKT_TIMEOUT_EN
        tmr_d        = '0;
        k_d          = k_q;
`endif
        case (state_q)
            ST_IDLE: begin
                byte_d = '0;
                smp_d  = '0;
                if (!run) seq_d = '0;
                if (run && fifo_rdusedw >= c_full_used) begin
                    state_d = ST_REQ;
`ifdef MIC_PKT_TIMEOUT_EN
                    k_d     = c_full_pkt;
                end else if (run && fifo_rdusedw != '0) begin
                    if (tmr_q == c_tmr_last) begin
                        state_d = ST_REQ;
                        k_d     = c_smp_w'(fifo_rdusedw);
                    end else begin
                        tmr_d = tmr_q + 1'b1;
                    end
`endif
                end
            end
            ST_REQ: begin
                if (tx_grant)  state_d = ST_SEQ;
                else if (!run) state_d = ST_IDLE;
            end
            ST_SEQ: begin
                tx_valid_d = 1'b1;
                tx_data_d  = w_hdr[31:24];
                byte_d     = byte_q + 2'd1;
                if (byte_q == 2'd3) state_d = ST_RD;
            end
            ST_RD: state_d = ST_MSB;
            ST_MSB: begin
                tx_valid_d = 1'b1;
                tx_data_d  = got_q ? fifo_rdata[15:8] : 8'h00;
                lsb_d      = got_q ? fifo_rdata[7:0]  : 8'h00;
                state_d    = ST_LSB;
            end
            ST_LSB: begin
                tx_valid_d = 1'b1;
                tx_data_d  = lsb_q;
                smp_d      = smp_q + 1'b1;
                if (smp_q == c_last_smp) begin
                    tx_last_d = 1'b1;
                    seq_d     = seq_q + 32'd1;
                    state_d   = ST_IDLE;
                end else begin
                    state_d   = ST_RD;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        tx_req_d = (state_d == ST_REQ);
`ifdef MIC_PKT_TIMEOUT_EN
        // Slots beyond the timeout snapshot are padding, not underflows.
        w_live = (smp_d < k_d);
`endif
        if (state_d == ST_RD && w_live) begin
            if (fifo_empty) underflow_d  = 1'b1;
            else            fifo_rdreq_d = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            seq_q        <= '0;
            byte_q       <= '0;
            smp_q        <= '0;
            lsb_q        <= '0;
            got_q        <= 1'b0;
            fifo_rdreq_q <= 1'b0;
            tx_req_q     <= 1'b0;
            tx_data_q    <= '0;
            tx_valid_q   <= 1'b0;
            tx_last_q    <= 1'b0;
            underflow_q  <= 1'b0;
`ifdef MIC_PKT_TIMEOUT_EN
            tmr_q        <= '0;
            k_q          <= '0;
`endif
        end else begin
            state_q      <= state_d;
            seq_q        <= seq_d;
            byte_q       <= byte_d;
            smp_q        <= smp_d;
            lsb_q        <= lsb_d;
            got_q        <= got_d;
            fifo_rdreq_q <= fifo_rdreq_d;
            tx_req_q     <= tx_req_d;
            tx_data_q    <= tx_data_d;
            tx_valid_q   <= tx_valid_d;
            tx_last_q    <= tx_last_d;
            underflow_q  <= underflow_d;
`ifdef MIC_PKT_TIMEOUT_EN
            tmr_q        <= tmr_d;
            k_q          <= k_d;
`endif
        end
    end

    assign fifo_rdreq = fifo_rdreq_q;
    assign tx_req     = tx_req_q;
    assign tx_data    = tx_data_q;
    assign tx_valid   = tx_valid_q;
    assign tx_last    = tx_last_q;
    assign underflow  = underflow_q;

endmodule
`default_nettype wire
